// File: rtl/mem_stage_if.sv
// Signal bundle between the execute stage, mem_stage, the data SRAM and writeback.
// The slave modport is the mem_stage view; master is the surrounding pipeline/SRAM.
interface mem_stage_if;
    logic        ex_valid;
    logic        ex_wen;
    logic [4:0]  ex_regdst;
    logic [31:0] ex_alu_result;
    logic        ex_is_load;
    logic        ex_is_store;
    logic [1:0]  ex_mem_size;
    logic        ex_load_unsigned;
    logic [31:0] ex_store_data;
    logic        mem_allowin;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        wb_allowin;
    logic        mem_valid;
    logic        mem_wen;
    logic [4:0]  mem_regdst;
    logic [31:0] mem_wdata;
    logic        mem_addr_err;
    logic        fwd_mem_wen;
    logic [4:0]  fwd_mem_regdst;
    logic [31:0] fwd_mem_wdata;

    modport slave (
        input  ex_valid, ex_wen, ex_regdst, ex_alu_result, ex_is_load, ex_is_store,
               ex_mem_size, ex_load_unsigned, ex_store_data, data_sram_rdata, wb_allowin,
        output mem_allowin, data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
               mem_valid, mem_wen, mem_regdst, mem_wdata, mem_addr_err,
               fwd_mem_wen, fwd_mem_regdst, fwd_mem_wdata
    );

    modport master (
        output ex_valid, ex_wen, ex_regdst, ex_alu_result, ex_is_load, ex_is_store,
               ex_mem_size, ex_load_unsigned, ex_store_data, data_sram_rdata, wb_allowin,
        input  mem_allowin, data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
               mem_valid, mem_wen, mem_regdst, mem_wdata, mem_addr_err,
               fwd_mem_wen, fwd_mem_regdst, fwd_mem_wdata
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues data-SRAM requests from EX, holds one
// instruction, aligns/extends load data and keeps it valid across writeback stalls.
module mem_stage (
    input  logic        clk,
    input  logic        resetn,
    mem_stage_if.slave  bus
);
    logic        valid_r, wen_r, is_load_r, unsigned_r, addr_err_r, first_r, held_r;
    logic [4:0]  regdst_r;
    logic [1:0]  size_r;
    logic [31:0] result_r, rdata_buf;

    logic        accept, ex_mem_op, ex_half, ex_word, ex_addr_err, sram_go;
    logic [31:0] raw, aligned;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign bus.mem_allowin = !valid_r | bus.wb_allowin;
    assign accept          = bus.ex_valid & bus.mem_allowin;

    assign ex_mem_op   = bus.ex_is_load | bus.ex_is_store;
    assign ex_half     = (bus.ex_mem_size == 2'd1);
    assign ex_word     = bus.ex_mem_size[1];
    assign ex_addr_err = ex_mem_op & ((ex_half & bus.ex_alu_result[0]) |
                                      (ex_word & (|bus.ex_alu_result[1:0])));
    // Gated by resetn so nothing reaches the SRAM while the stage is being reset.
    assign sram_go     = accept & resetn & ex_mem_op & !ex_addr_err;

    always_comb begin
        bus.data_sram_en    = 1'b0;
        bus.data_sram_wen   = '0;
        bus.data_sram_addr  = '0;
        bus.data_sram_wdata = '0;
        if (sram_go) begin
            bus.data_sram_en   = 1'b1;
            bus.data_sram_addr = bus.ex_alu_result;
            case (bus.ex_mem_size)
                2'd0:    bus.data_sram_wdata = {4{bus.ex_store_data[7:0]}};
                2'd1:    bus.data_sram_wdata = {2{bus.ex_store_data[15:0]}};
                default: bus.data_sram_wdata = bus.ex_store_data;
            endcase
            if (bus.ex_is_store) begin
                case (bus.ex_mem_size)
                    2'd0:    bus.data_sram_wen = 4'b0001 << bus.ex_alu_result[1:0];
                    2'd1:    bus.data_sram_wen = bus.ex_alu_result[1] ? 4'b1100 : 4'b0011;
                    default: bus.data_sram_wen = 4'b1111;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_r    <= 1'b0;
            wen_r      <= 1'b0;
            regdst_r   <= '0;
            result_r   <= '0;
            size_r     <= '0;
            unsigned_r <= 1'b0;
            is_load_r  <= 1'b0;
            addr_err_r <= 1'b0;
            first_r    <= 1'b0;
            held_r     <= 1'b0;
            rdata_buf  <= '0;
        end else begin
            if (accept) begin
                valid_r    <= 1'b1;
                wen_r      <= bus.ex_wen & !ex_addr_err;
                regdst_r   <= bus.ex_regdst;
                result_r   <= bus.ex_alu_result;
                size_r     <= bus.ex_mem_size;
                unsigned_r <= bus.ex_load_unsigned;
                is_load_r  <= bus.ex_is_load;
                addr_err_r <= ex_addr_err;
                first_r    <= bus.ex_is_load & !ex_addr_err;
                held_r     <= 1'b0;
            end else begin
                if (bus.wb_allowin)
                    valid_r <= 1'b0;
                first_r <= 1'b0;
                if (first_r)
                    held_r <= 1'b1;
            end
            // SRAM data is only valid in the first cycle; keep a copy for stalls.
            if (first_r)
                rdata_buf <= bus.data_sram_rdata;
        end
    end

    assign raw = held_r ? rdata_buf : bus.data_sram_rdata;

    always_comb begin
        case (result_r[1:0])
            2'd0:    lane_b = raw[7:0];
            2'd1:    lane_b = raw[15:8];
            2'd2:    lane_b = raw[23:16];
            default: lane_b = raw[31:24];
        endcase
        lane_h = result_r[1] ? raw[31:16] : raw[15:0];
        case (size_r)
            2'd0:    aligned = {{24{lane_b[7] & !unsigned_r}}, lane_b};
            2'd1:    aligned = {{16{lane_h[15] & !unsigned_r}}, lane_h};
            default: aligned = raw;
        endcase
    end

    assign bus.mem_valid      = valid_r;
    assign bus.mem_wen        = wen_r;
    assign bus.mem_regdst     = regdst_r;
    assign bus.mem_wdata      = is_load_r ? aligned : result_r;
    assign bus.mem_addr_err   = addr_err_r;
    assign bus.fwd_mem_wen    = valid_r & wen_r;
    assign bus.fwd_mem_regdst = regdst_r;
    assign bus.fwd_mem_wdata  = bus.mem_wdata;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: loads, store lanes, stall hold, misalignment, reset mid-stall.
module tb_mem_stage;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   total = 0;
    int   bad = 0;

    mem_stage_if bus ();
    mem_stage dut (.clk(clk), .resetn(resetn), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input logic [4:0] rd, input logic [31:0] a,
                         input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                         input logic [31:0] sd);
        bus.ex_valid         = v;
        bus.ex_wen           = w;
        bus.ex_regdst        = rd;
        bus.ex_alu_result    = a;
        bus.ex_is_load       = ld;
        bus.ex_is_store      = st;
        bus.ex_mem_size      = sz;
        bus.ex_load_unsigned = uns;
        bus.ex_store_data    = sd;
    endtask

    task automatic idle;
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0);
    endtask

    localparam logic [31:0] WORD = 32'h8081_8283;

    task automatic do_load(input string tag, input logic [31:0] a, input logic [1:0] sz,
                           input logic uns, input logic [4:0] rd, input logic [31:0] exp);
        drive(1'b1, 1'b1, rd, a, 1'b1, 1'b0, sz, uns, 32'h0);
        #1;
        chk({tag, " sram_en"}, {31'b0, bus.data_sram_en}, 32'd1);
        chk({tag, " sram_wen"}, {28'b0, bus.data_sram_wen}, 32'd0);
        chk({tag, " sram_addr"}, bus.data_sram_addr, a);
        tick;
        idle;
        bus.data_sram_rdata = WORD;
        #1;
        chk({tag, " valid"}, {31'b0, bus.mem_valid}, 32'd1);
        chk({tag, " regdst"}, {27'b0, bus.mem_regdst}, {27'b0, rd});
        chk({tag, " wdata"}, bus.mem_wdata, exp);
        chk({tag, " fwd_wen"}, {31'b0, bus.fwd_mem_wen}, 32'd1);
        chk({tag, " fwd_wdata"}, bus.fwd_mem_wdata, exp);
    endtask

    task automatic do_store(input string tag, input logic [31:0] a, input logic [1:0] sz,
                            input logic [31:0] sd, input logic [3:0] ewen, input logic [31:0] ewd);
        drive(1'b1, 1'b0, 5'd3, a, 1'b0, 1'b1, sz, 1'b0, sd);
        #1;
        chk({tag, " sram_en"}, {31'b0, bus.data_sram_en}, 32'd1);
        chk({tag, " sram_wen"}, {28'b0, bus.data_sram_wen}, {28'b0, ewen});
        chk({tag, " sram_wdata"}, bus.data_sram_wdata, ewd);
        tick;
        idle;
        #1;
        chk({tag, " valid"}, {31'b0, bus.mem_valid}, 32'd1);
        chk({tag, " mem_wen"}, {31'b0, bus.mem_wen}, 32'd0);
        chk({tag, " wdata"}, bus.mem_wdata, a);
    endtask

    initial begin
        bus.wb_allowin      = 1'b1;
        bus.data_sram_rdata = 32'h0;
        // A store presented during reset must not reach the SRAM.
        drive(1'b1, 1'b0, 5'd1, 32'h200, 1'b0, 1'b1, 2'd2, 1'b0, 32'hFFFF_FFFF);
        repeat (2) tick;
        chk("rst sram_en", {31'b0, bus.data_sram_en}, 32'd0);
        chk("rst sram_wen", {28'b0, bus.data_sram_wen}, 32'd0);
        chk("rst valid", {31'b0, bus.mem_valid}, 32'd0);
        chk("rst allowin", {31'b0, bus.mem_allowin}, 32'd1);
        chk("rst wdata", bus.mem_wdata, 32'h0);
        chk("rst regdst", {27'b0, bus.mem_regdst}, 32'd0);
        chk("rst err", {31'b0, bus.mem_addr_err}, 32'd0);
        resetn = 1'b1;
        idle;
        tick;

        // Back-to-back loads: each one enters while the previous result is on mem_*.
        do_load("lw",  32'h100, 2'd2, 1'b0, 5'd5, 32'h8081_8283);
        do_load("lb",  32'h103, 2'd0, 1'b0, 5'd6, 32'hFFFF_FF80);
        do_load("lbu", 32'h103, 2'd0, 1'b1, 5'd7, 32'h0000_0080);
        do_load("lh",  32'h102, 2'd1, 1'b0, 5'd8, 32'hFFFF_8081);
        do_load("lhu", 32'h100, 2'd1, 1'b1, 5'd9, 32'h0000_8283);
        do_load("lb0", 32'h100, 2'd0, 1'b0, 5'd10, 32'hFFFF_FF83);

        do_store("sb", 32'h201, 2'd0, 32'h0000_00AB, 4'b0010, 32'hABAB_ABAB);
        do_store("sh", 32'h202, 2'd1, 32'h0000_1234, 4'b1100, 32'h1234_1234);
        do_store("sw", 32'h200, 2'd2, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);
        tick;
        chk("drain valid", {31'b0, bus.mem_valid}, 32'd0);
        chk("drain fwd_wen", {31'b0, bus.fwd_mem_wen}, 32'd0);

        // Stall: lbu at 0x101 must keep 0x82 while the SRAM output turns to garbage.
        drive(1'b1, 1'b1, 5'd11, 32'h101, 1'b1, 1'b0, 2'd0, 1'b1, 32'h0);
        tick;
        bus.wb_allowin = 1'b0;
        bus.data_sram_rdata = WORD;
        drive(1'b1, 1'b0, 5'd12, 32'h204, 1'b0, 1'b1, 2'd2, 1'b0, 32'h1111_2222);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall wdata", bus.mem_wdata, 32'h0000_0082);
            chk("stall allowin", {31'b0, bus.mem_allowin}, 32'd0);
            chk("stall sram_en", {31'b0, bus.data_sram_en}, 32'd0);
            chk("stall valid", {31'b0, bus.mem_valid}, 32'd1);
            tick;
            bus.data_sram_rdata = 32'hDEAD_BEEF ^ i;
        end
        bus.wb_allowin = 1'b1;
        #1;
        chk("release allowin", {31'b0, bus.mem_allowin}, 32'd1);
        chk("release sram_en", {31'b0, bus.data_sram_en}, 32'd1);
        tick;
        idle;
        #1;
        chk("release regdst", {27'b0, bus.mem_regdst}, 32'd12);
        chk("release wdata", bus.mem_wdata, 32'h204);

        // Misaligned accesses: no SRAM access, write enable suppressed.
        drive(1'b1, 1'b1, 5'd13, 32'h102, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0);
        #1;
        chk("lw mis sram_en", {31'b0, bus.data_sram_en}, 32'd0);
        tick;
        drive(1'b1, 1'b1, 5'd14, 32'h301, 1'b0, 1'b1, 2'd1, 1'b0, 32'h5555);
        #1;
        chk("lw mis err", {31'b0, bus.mem_addr_err}, 32'd1);
        chk("lw mis wen", {31'b0, bus.mem_wen}, 32'd0);
        chk("sh mis sram_en", {31'b0, bus.data_sram_en}, 32'd0);
        chk("sh mis sram_wen", {28'b0, bus.data_sram_wen}, 32'd0);
        tick;
        idle;
        #1;
        chk("sh mis err", {31'b0, bus.mem_addr_err}, 32'd1);
        chk("sh mis wen", {31'b0, bus.mem_wen}, 32'd0);
        chk("sh mis valid", {31'b0, bus.mem_valid}, 32'd1);

        // Reset while a load is held by a stall.
        drive(1'b1, 1'b1, 5'd9, 32'h100, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0);
        tick;
        bus.wb_allowin = 1'b0;
        bus.data_sram_rdata = WORD;
        drive(1'b1, 1'b0, 5'd2, 32'h200, 1'b0, 1'b1, 2'd2, 1'b0, 32'h7777_7777);
        #1;
        chk("pre-rst wdata", bus.mem_wdata, WORD);
        resetn = 1'b0;
        #1;
        chk("in-rst sram_wen", {28'b0, bus.data_sram_wen}, 32'd0);
        tick;
        chk("post-rst valid", {31'b0, bus.mem_valid}, 32'd0);
        chk("post-rst wen", {31'b0, bus.mem_wen}, 32'd0);
        chk("post-rst regdst", {27'b0, bus.mem_regdst}, 32'd0);
        chk("post-rst wdata", bus.mem_wdata, 32'h0);
        chk("post-rst err", {31'b0, bus.mem_addr_err}, 32'd0);
        chk("post-rst fwd_wen", {31'b0, bus.fwd_mem_wen}, 32'd0);
        chk("post-rst fwd_regdst", {27'b0, bus.fwd_mem_regdst}, 32'd0);
        chk("post-rst fwd_wdata", bus.fwd_mem_wdata, 32'h0);
        chk("post-rst allowin", {31'b0, bus.mem_allowin}, 32'd1);
        chk("post-rst sram_wen", {28'b0, bus.data_sram_wen}, 32'd0);
        chk("post-rst sram_en", {31'b0, bus.data_sram_en}, 32'd0);
        resetn = 1'b1;
        idle;
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage CPU, between the execute stage and `writeback_stage`. It issues data-SRAM reads and writes from execute-stage outputs and holds one instruction in its pipeline register. It aligns and sign- or zero-extends load data, and presents the final register-write triple plus forwarding data to the downstream stage. Flow control is a valid/allowin handshake, so a stalled writeback holds the instruction and its load data.

## Interface
Parameters: none.

Clock and reset: one clock; reset is synchronous and active-low.

- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  synchronous active-low reset
- ex_valid  in  1  execute stage presents an instruction
- ex_wen  in  1  instruction writes the register file
- ex_regdst  in  5  destination register
- ex_alu_result  in  32  ALU result / memory address
- ex_is_load  in  1  load instruction
- ex_is_store  in  1  store instruction
- ex_mem_size  in  2  0 = byte, 1 = half, 2 = word; 3 treated as word
- ex_load_unsigned  in  1  zero-extend instead of sign-extend
- ex_store_data  in  32  store source register value
- mem_allowin  out  1  stage accepts a new instruction this cycle
- data_sram_en  out  1  SRAM access enable
- data_sram_wen  out  4  byte write enables
- data_sram_addr  out  32  byte address
- data_sram_wdata  out  32  lane-replicated store data
- data_sram_rdata  in  32  read data, valid exactly one cycle after an enabled read
- wb_allowin  in  1  writeback accepts this cycle
- mem_valid  out  1  pipeline register holds a valid instruction
- mem_wen  out  1  register write enable to writeback
- mem_regdst  out  5  destination register to writeback
- mem_wdata  out  32  final register write data
- mem_addr_err  out  1  misaligned access flagged for this instruction
- fwd_mem_wen  out  1  forwarding write enable, = mem_valid & mem_wen
- fwd_mem_regdst  out  5  forwarding destination
- fwd_mem_wdata  out  32  forwarding data, = mem_wdata

## Operation
Accept and handshake:
- accept = ex_valid & mem_allowin.
- mem_allowin = !mem_valid | wb_allowin.
- Ready-go is always 1 because SRAM latency is fixed.
- On accept, register wen, regdst, addr[1:0], size, unsigned, is_load and addr_err, and set valid_r.
- Else if wb_allowin, clear valid_r.

Misalignment:
- addr_err = (size == half & addr[0]) | (size == word & addr[1:0] != 0), qualified by load or store.
- On error, the SRAM is not enabled, mem_wen is forced 0, and mem_addr_err is set.

SRAM request (combinational from EX inputs):
- en = accept & (is_load | is_store) & !addr_err.
- wen is applied only for stores:
  - byte: 4'b0001 << addr[1:0]
  - half: addr[1] ? 4'b1100 : 4'b0011
  - word: 4'b1111
- addr = ex_alu_result.
- wdata replication:
  - byte: {4{data[7:0]}}
  - half: {2{data[15:0]}}
  - word: data

Load data hold:
- The cycle after a load is accepted, `first` = 1 and data_sram_rdata is used directly. It is also captured into `rdata_buf`, and `held` is set.
- While `held` = 1 (stalled), `rdata_buf` is used.
- `held` clears when a new instruction is accepted.
- Guarantees: the SRAM output may change after its valid cycle, and correct data survives any stall length.

Load alignment:
- Select the byte at addr[1:0] or the half at addr[1], then sign- or zero-extend per the unsigned flag.
- For loads, mem_wdata is the aligned value; otherwise it is the registered ALU result.

## Timing
- Reset (resetn = 0 at a clock edge): valid_r, held and every pipeline register go to 0. Consequently mem_valid = 0, mem_wen = 0, mem_regdst = 0, mem_wdata = 0, mem_addr_err = 0, fwd_* = 0, and mem_allowin = 1.
- SRAM outputs are 0 when not accepting, including during reset.
- Latency: EX cycle N issues the request; the result is on mem_* in cycle N+1.
- Throughput is one instruction per cycle when wb_allowin = 1.
- Stall: mem_valid = 1 & wb_allowin = 0 gives mem_allowin = 0. No SRAM access is issued and all mem_* outputs hold stable.
- Simultaneous wb_allowin = 1 and ex_valid = 1: the register is replaced in the same edge with no bubble.
- If the stage is drained while ex_valid = 0, mem_valid falls the next cycle.
- Reset mid-stall discards the held instruction, and no SRAM write follows.
- Stores never generate a register write unless ex_wen is set by the decoder; the stage does not alter ex_wen except on addr_err.

## Test plan
- Word load, no stall: mem[0x100] = 0x8081_8283, lw at 0x100 (regdst 5) → data_sram_en = 1, wen = 0 in cycle N; cycle N+1 mem_valid = 1, mem_regdst = 5, mem_wdata = 0x8081_8283.
- Byte/half extension: same word. lb at 0x103 → 0xFFFF_FF80; lbu at 0x103 → 0x0000_0080; lh at 0x102 → 0xFFFF_8081; lhu at 0x100 → 0x0000_8283.
- Store lanes: sb 0xAB at 0x201 → wen = 4'b0010, wdata = 0xABAB_ABAB. sh 0x1234 at 0x202 → wen = 4'b1100, wdata = 0x1234_1234. sw at 0x200 → 4'b1111.
- Stall hold: a load is accepted, wb_allowin = 0 for 3 cycles, and the bench drives data_sram_rdata to garbage after the first cycle → mem_wdata stays at the correct aligned value, mem_allowin = 0 and en = 0 throughout. Release → the next instruction enters the following cycle.
- Misaligned: lw at 0x102, then sh at 0x301 → data_sram_en = 0 both times; mem_addr_err = 1 and mem_wen = 0 for each.
- Reset mid-stall: a valid load is held and resetn is asserted for one edge → mem_valid = 0, all mem_*/fwd_* = 0, mem_allowin = 1, and no SRAM write.
